// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes, operand-type codes and the decoded field bundle.
// The ALU_MUL..ALU_REMU codes are only produced when RV32M_EN is defined.
package decode_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 6;
    localparam int unsigned OPT_W = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALU_W-1:0] ALU_NOP    = 6'd0;
    localparam logic [ALU_W-1:0] ALU_ADD    = 6'd1;
    localparam logic [ALU_W-1:0] ALU_SUB    = 6'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 6'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 6'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 6'd5;
    localparam logic [ALU_W-1:0] ALU_OR     = 6'd6;
    localparam logic [ALU_W-1:0] ALU_AND    = 6'd7;
    localparam logic [ALU_W-1:0] ALU_SLL    = 6'd8;
    localparam logic [ALU_W-1:0] ALU_SRL    = 6'd9;
    localparam logic [ALU_W-1:0] ALU_SRA    = 6'd10;
    localparam logic [ALU_W-1:0] ALU_LUI    = 6'd11;
    localparam logic [ALU_W-1:0] ALU_JAL    = 6'd12;
    localparam logic [ALU_W-1:0] ALU_JALR   = 6'd13;
    localparam logic [ALU_W-1:0] ALU_BEQ    = 6'd14;
    localparam logic [ALU_W-1:0] ALU_BNE    = 6'd15;
    localparam logic [ALU_W-1:0] ALU_BLT    = 6'd16;
    localparam logic [ALU_W-1:0] ALU_BGE    = 6'd17;
    localparam logic [ALU_W-1:0] ALU_BLTU   = 6'd18;
    localparam logic [ALU_W-1:0] ALU_BGEU   = 6'd19;
    localparam logic [ALU_W-1:0] ALU_LB     = 6'd20;
    localparam logic [ALU_W-1:0] ALU_LH     = 6'd21;
    localparam logic [ALU_W-1:0] ALU_LW     = 6'd22;
    localparam logic [ALU_W-1:0] ALU_LBU    = 6'd23;
    localparam logic [ALU_W-1:0] ALU_LHU    = 6'd24;
    localparam logic [ALU_W-1:0] ALU_SB     = 6'd25;
    localparam logic [ALU_W-1:0] ALU_SH     = 6'd26;
    localparam logic [ALU_W-1:0] ALU_SW     = 6'd27;
    // M codes are contiguous in funct3 order so they can be formed as ALU_MUL + funct3
    localparam logic [ALU_W-1:0] ALU_MUL    = 6'd28;
    localparam logic [ALU_W-1:0] ALU_MULH   = 6'd29;
    localparam logic [ALU_W-1:0] ALU_MULHSU = 6'd30;
    localparam logic [ALU_W-1:0] ALU_MULHU  = 6'd31;
    localparam logic [ALU_W-1:0] ALU_DIV    = 6'd32;
    localparam logic [ALU_W-1:0] ALU_DIVU   = 6'd33;
    localparam logic [ALU_W-1:0] ALU_REM    = 6'd34;
    localparam logic [ALU_W-1:0] ALU_REMU   = 6'd35;

    localparam logic [OPT_W-1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [OPT_W-1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [OPT_W-1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [OPT_W-1:0] OP_TYPE_PC   = 2'd3;

    typedef struct packed {
        logic [REG_W-1:0] srcreg1_num;
        logic [REG_W-1:0] srcreg2_num;
        logic [REG_W-1:0] dstreg_num;
        logic [XLEN-1:0]  imm;
        logic [ALU_W-1:0] alucode;
        logic [OPT_W-1:0] aluop1_type;
        logic [OPT_W-1:0] aluop2_type;
        logic             reg_we;
        logic             is_load;
        logic             is_store;
        logic             is_halt;
        logic             is_illegal;
    } dec_fields_t;

    // ECALL/EBREAK family: SYSTEM opcode with funct3 = 000
    function automatic logic is_halt_word(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OPC_SYSTEM) && (funct3 == 3'b000);
    endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I instruction decoder: instruction word in, decoded field bundle out.
// Define RV32M_EN to also decode the RV32M multiply/divide group.
module decode_core
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] ir,
    output dec_fields_t     fields
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_j;
    logic [XLEN-1:0]  shamt;
    logic             we;
    logic             illegal;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign shamt  = {27'b0, ir[24:20]};

    always_comb begin
        fields  = '0;
        we      = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                fields.dstreg_num  = rd;
                fields.imm         = imm_u;
                fields.alucode     = ALU_LUI;
                fields.aluop2_type = OP_TYPE_IMM;
                we                 = 1'b1;
            end
            OPC_AUIPC: begin
                fields.dstreg_num  = rd;
                fields.imm         = imm_u;
                fields.alucode     = ALU_ADD;
                fields.aluop1_type = OP_TYPE_PC;
                fields.aluop2_type = OP_TYPE_IMM;
                we                 = 1'b1;
            end
            OPC_JAL: begin
                fields.dstreg_num  = rd;
                fields.imm         = imm_j;
                fields.alucode     = ALU_JAL;
                fields.aluop1_type = OP_TYPE_PC;
                fields.aluop2_type = OP_TYPE_IMM;
                we                 = 1'b1;
            end
            OPC_JALR: begin
                fields.srcreg1_num = rs1;
                fields.dstreg_num  = rd;
                fields.imm         = imm_i;
                fields.alucode     = ALU_JALR;
                fields.aluop1_type = OP_TYPE_REG;
                fields.aluop2_type = OP_TYPE_IMM;
                we                 = 1'b1;
            end
            OPC_BRANCH: begin
                fields.srcreg1_num = rs1;
                fields.srcreg2_num = rs2;
                fields.imm         = imm_b;
                fields.aluop1_type = OP_TYPE_REG;
                fields.aluop2_type = OP_TYPE_REG;
                case (funct3)
                    3'b000:  fields.alucode = ALU_BEQ;
                    3'b001:  fields.alucode = ALU_BNE;
                    3'b100:  fields.alucode = ALU_BLT;
                    3'b101:  fields.alucode = ALU_BGE;
                    3'b110:  fields.alucode = ALU_BLTU;
                    3'b111:  fields.alucode = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fields.srcreg1_num = rs1;
                fields.dstreg_num  = rd;
                fields.imm         = imm_i;
                fields.aluop1_type = OP_TYPE_REG;
                fields.aluop2_type = OP_TYPE_IMM;
                fields.is_load     = 1'b1;
                we                 = 1'b1;
                case (funct3)
                    3'b000:  fields.alucode = ALU_LB;
                    3'b001:  fields.alucode = ALU_LH;
                    3'b010:  fields.alucode = ALU_LW;
                    3'b100:  fields.alucode = ALU_LBU;
                    3'b101:  fields.alucode = ALU_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                fields.srcreg1_num = rs1;
                fields.srcreg2_num = rs2;
                fields.imm         = imm_s;
                fields.aluop1_type = OP_TYPE_REG;
                fields.aluop2_type = OP_TYPE_REG;
                fields.is_store    = 1'b1;
                case (funct3)
                    3'b000:  fields.alucode = ALU_SB;
                    3'b001:  fields.alucode = ALU_SH;
                    3'b010:  fields.alucode = ALU_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                fields.srcreg1_num = rs1;
                fields.dstreg_num  = rd;
                fields.imm         = imm_i;
                fields.aluop1_type = OP_TYPE_REG;
                fields.aluop2_type = OP_TYPE_IMM;
                we                 = 1'b1;
                case (funct3)
                    3'b000: fields.alucode = ALU_ADD;
                    3'b010: fields.alucode = ALU_SLT;
                    3'b011: fields.alucode = ALU_SLTU;
                    3'b100: fields.alucode = ALU_XOR;
                    3'b110: fields.alucode = ALU_OR;
                    3'b111: fields.alucode = ALU_AND;
                    3'b001: begin
                        fields.imm = shamt;
                        if (funct7 == F7_BASE) fields.alucode = ALU_SLL;
                        else                   illegal = 1'b1;
                    end
                    default: begin
                        fields.imm = shamt;
                        if (funct7 == F7_BASE)     fields.alucode = ALU_SRL;
                        else if (funct7 == F7_ALT) fields.alucode = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                fields.srcreg1_num = rs1;
                fields.srcreg2_num = rs2;
                fields.dstreg_num  = rd;
                fields.aluop1_type = OP_TYPE_REG;
                fields.aluop2_type = OP_TYPE_REG;
                we                 = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  fields.alucode = ALU_ADD;
                        3'b001:  fields.alucode = ALU_SLL;
                        3'b010:  fields.alucode = ALU_SLT;
                        3'b011:  fields.alucode = ALU_SLTU;
                        3'b100:  fields.alucode = ALU_XOR;
                        3'b101:  fields.alucode = ALU_SRL;
                        3'b110:  fields.alucode = ALU_OR;
                        default: fields.alucode = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    fields.alucode = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    fields.alucode = ALU_SRA;
`ifdef RV32M_EN
                end else if (funct7 == F7_MULDIV) begin
                    fields.alucode = ALU_MUL + ALU_W'(funct3);
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) fields.is_halt = 1'b1;
                else                  illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal words collapse to an all-quiet bundle; x0 is never written
        if (illegal) begin
            fields            = '0;
            fields.is_illegal = 1'b1;
        end else begin
            fields.reg_we = we && (fields.dstreg_num != '0);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: circular instruction queue feeding a registered decoded output stage, with flush and halt.
// RV32M_EN (passed through to decode_core) enables the RV32M decode group.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_ir,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [REG_W-1:0]           srcreg1_num,
    output logic [REG_W-1:0]           srcreg2_num,
    output logic [REG_W-1:0]           dstreg_num,
    output logic [XLEN-1:0]            imm,
    output logic [ALU_W-1:0]           alucode,
    output logic [OPT_W-1:0]           aluop1_type,
    output logic [OPT_W-1:0]           aluop2_type,
    output logic                       reg_we,
    output logic                       is_load,
    output logic                       is_store,
    output logic                       is_halt,
    output logic                       is_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  ir_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             halted;
    logic             push;
    logic             load;
    dec_fields_t      head_fields;
    dec_fields_t      stage_fields;

    assign in_ready = rst_n && (count < CNT_W'(DEPTH)) && !halted && !flush;
    assign push     = in_valid && in_ready;
    // The stage refills from the head whenever it is empty or its word is being taken
    assign load     = (!out_valid || out_ready) && (count != '0) && !flush;

    decode_core u_core (
        .ir     (ir_mem[rd_ptr]),
        .fields (head_fields)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr] <= in_ir;
            pc_mem[wr_ptr] <= in_pc;
        end
    end

    // Queue pointers, occupancy and the sticky halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(load);
            if (push && is_halt_word(in_ir[6:0], in_ir[14:12])) halted <= 1'b1;
        end
    end

    // Output stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            stage_fields <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_pc       <= pc_mem[rd_ptr];
            stage_fields <= head_fields;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign srcreg1_num = stage_fields.srcreg1_num;
    assign srcreg2_num = stage_fields.srcreg2_num;
    assign dstreg_num  = stage_fields.dstreg_num;
    assign imm         = stage_fields.imm;
    assign alucode     = stage_fields.alucode;
    assign aluop1_type = stage_fields.aluop1_type;
    assign aluop2_type = stage_fields.aluop2_type;
    assign reg_we      = stage_fields.reg_we;
    assign is_load     = stage_fields.is_load;
    assign is_store    = stage_fields.is_store;
    assign is_halt     = stage_fields.is_halt;
    assign is_illegal  = stage_fields.is_illegal;

endmodule
